// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-state encoding and PC defaults for pc_fetch and npc
package mips_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_3040;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - PC register and req/ack instruction-fetch sequencer with EPC/EXL capture
// Optional misaligned-npc trap (addr_err port) is built when PC_ALIGN_CHECK_EN is defined.
module pc_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        flush,
    input  logic        intreq,
    input  logic        eret,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        int_ack,
    output logic [29:0] epc,
`ifdef PC_ALIGN_CHECK_EN
    output logic        addr_err,
`endif
    output logic        exl
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [29:0] r_epc;
    logic        r_exl;
    logic        r_drop;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_nxt;
    logic        w_pc_we;
    logic        w_instr_we;
    logic        w_drop_nxt;
    logic        w_take_int;
    logic        w_clr_exl;
    logic        w_trap_align;
    logic        w_misal;
    logic        w_req;
    logic        w_valid;

    assign w_pc_plus4 = r_pc + 32'd4;

`ifdef PC_ALIGN_CHECK_EN
    assign w_misal  = |npc[1:0];
    assign addr_err = w_trap_align;
`else
    assign w_misal  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_req        = 1'b0;
        w_valid      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_nxt     = word_align(npc);
        w_instr_we   = 1'b0;
        w_drop_nxt   = r_drop;
        w_take_int   = 1'b0;
        w_clr_exl    = 1'b0;
        w_trap_align = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                w_req = 1'b1;
                // A flush with no ack leaves a response in flight that must be discarded.
                if (flush) begin
                    w_pc_we    = 1'b1;
                    w_drop_nxt = !imem_ack;
                end else if (imem_ack) begin
                    if (r_drop) begin
                        w_drop_nxt = 1'b0;
                    end else begin
                        w_instr_we  = 1'b1;
                        w_state_nxt = S_VALID;
                    end
                end
            end
            S_VALID: begin
                w_valid = 1'b1;
                if (!stall || flush) begin
                    w_pc_we     = 1'b1;
                    w_state_nxt = S_REQ;
                    if (w_misal) begin
                        w_trap_align = 1'b1;
                        w_take_int   = 1'b1;
                        w_pc_nxt     = HANDLER_PC;
                    end else if (eret) begin
                        w_clr_exl = 1'b1;
                    end else if (intreq && !r_exl) begin
                        w_take_int = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_epc   <= 30'd0;
            r_exl   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            if (w_pc_we) begin
                r_pc <= w_pc_nxt;
            end
            if (w_instr_we) begin
                r_instr <= imem_rdata;
            end
            r_drop <= w_drop_nxt;
            if (w_take_int) begin
                r_epc <= w_pc_plus4[31:2];
                r_exl <= 1'b1;
            end else if (w_clr_exl) begin
                r_exl <= 1'b0;
            end
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign instr       = r_instr;
    assign instr_valid = w_valid;
    assign int_ack     = w_take_int;
    assign epc         = r_epc;
    assign exl         = r_exl;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed and randomized bench for pc_fetch against a fetch-level reference model
module tb_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] HND_PC = 32'h0000_3040;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] npc;
    logic        stall;
    logic        flush;
    logic        intreq;
    logic        eret;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        int_ack;
    logic [29:0] epc;
    logic        exl;
`ifdef PC_ALIGN_CHECK_EN
    logic        addr_err;
`endif

    pc_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .npc         (npc),
        .stall       (stall),
        .flush       (flush),
        .intreq      (intreq),
        .eret        (eret),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr       (instr),
        .instr_valid (instr_valid),
        .int_ack     (int_ack),
        .epc         (epc),
`ifdef PC_ALIGN_CHECK_EN
        .addr_err    (addr_err),
`endif
        .exl         (exl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model: "started" = one cycle out of reset, "holding" = an instruction is presented,
    // otherwise a fetch of m_pc is outstanding; m_drop marks a stale response still to come.
    bit          m_started;
    bit          m_have;
    bit          m_drop;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [29:0] m_epc;
    bit          m_exl;
    int          mem_wait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_have    = 1'b0;
        m_drop    = 1'b0;
        m_pc      = RST_PC;
        m_instr   = 32'd0;
        m_epc     = 30'd0;
        m_exl     = 1'b0;
    endtask

    task automatic idle_inputs();
        stall    = 1'b0;
        flush    = 1'b0;
        intreq   = 1'b0;
        eret     = 1'b0;
        imem_ack = 1'b0;
    endtask

    // Inputs are set just after a falling edge; check, advance the model, move to next falling edge.
    task automatic cycle();
        bit adv;
        bit misal;
        bit exp_int;
        #1;
        adv     = m_have && (!stall || flush);
        misal   = ALIGN_CHK && (npc[1:0] != 2'b00);
        exp_int = rst_n && adv && (misal || (!eret && intreq && !m_exl));
        chk("req",      {31'd0, imem_req},    {31'd0, rst_n && m_started && !m_have});
        chk("addr",     imem_addr,            m_pc);
        chk("pc",       pc,                   m_pc);
        chk("pc_plus4", pc_plus4,             m_pc + 32'd4);
        chk("valid",    {31'd0, instr_valid}, {31'd0, rst_n && m_have});
        chk("instr",    instr,                m_instr);
        chk("int_ack",  {31'd0, int_ack},     {31'd0, exp_int});
        chk("epc",      {2'b00, epc},         {2'b00, m_epc});
        chk("exl",      {31'd0, exl},         {31'd0, m_exl});
`ifdef PC_ALIGN_CHECK_EN
        chk("addr_err", {31'd0, addr_err},    {31'd0, rst_n && adv && misal});
`endif
        if (!rst_n) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (m_have) begin
            if (adv) begin
                if (misal) begin
                    m_epc = (m_pc + 32'd4) >> 2;
                    m_exl = 1'b1;
                    m_pc  = HND_PC;
                end else begin
                    if (eret) begin
                        m_exl = 1'b0;
                    end else if (intreq && !m_exl) begin
                        m_epc = (m_pc + 32'd4) >> 2;
                        m_exl = 1'b1;
                    end
                    m_pc = npc & ~32'd3;
                end
                m_have = 1'b0;
            end
        end else if (flush) begin
            m_pc   = npc & ~32'd3;
            m_drop = !imem_ack;
        end else if (imem_ack) begin
            if (m_drop) begin
                m_drop = 1'b0;
            end else begin
                m_instr = imem_rdata;
                m_have  = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    // Zero-wait fetch completion with decode stalled, leaving the instruction presented.
    task automatic fetch_now(input logic [31:0] word);
        idle_inputs();
        imem_ack   = 1'b1;
        imem_rdata = word;
        stall      = 1'b1;
        cycle();
    endtask

    task automatic advance_to(input logic [31:0] next);
        idle_inputs();
        npc = next;
        cycle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mem_wait    = 0;
        rst_n       = 1'b0;
        npc         = 32'd0;
        imem_rdata  = 32'd0;
        idle_inputs();
        model_reset();
        @(negedge clk);

        chk("rst_pc",    pc,                   RST_PC);
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr,                32'd0);
        chk("rst_epc",   {2'b00, epc},         32'd0);
        chk("rst_exl",   {31'd0, exl},         32'd0);

        // 1: reset release, zero-wait fetch
        rst_n = 1'b1;
        cycle();
        chk("t1_req",  {31'd0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr,         32'h0000_3000);
        npc = 32'h0000_3004;
        fetch_now(32'hA000_0001);
        chk("t1_valid", {31'd0, instr_valid}, 32'd1);
        chk("t1_instr", instr,                32'hA000_0001);
        chk("t1_pc4",   pc_plus4,             32'h0000_3004);

        // 2: stall holds instruction and pc
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            stall = 1'b1;
            npc   = 32'h0000_3010;
            cycle();
            chk("t2_hold_pc",    pc,                   32'h0000_3000);
            chk("t2_hold_instr", instr,                32'hA000_0001);
            chk("t2_hold_valid", {31'd0, instr_valid}, 32'd1);
        end
        advance_to(32'h0000_3010);
        chk("t2_pc",   pc,        32'h0000_3010);
        chk("t2_addr", imem_addr, 32'h0000_3010);

        // 3: flush while a response is outstanding
        idle_inputs();
        cycle();
        flush = 1'b1;
        npc   = 32'h0000_3100;
        cycle();
        idle_inputs();
        cycle();
        cycle();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_0001;
        cycle();
        chk("t3_addr",  imem_addr,            32'h0000_3100);
        chk("t3_valid", {31'd0, instr_valid}, 32'd0);
        fetch_now(32'hB000_0002);
        chk("t3_instr", instr, 32'hB000_0002);
        chk("t3_pc",    pc,    32'h0000_3100);

        // 4: interrupt entry, then a second request masked by exl
        advance_to(32'h0000_3008);
        fetch_now(32'hC000_0003);
        idle_inputs();
        intreq = 1'b1;
        npc    = 32'h0000_3040;
        #1;
        chk("t4_int_ack", {31'd0, int_ack}, 32'd1);
        cycle();
        chk("t4_epc", {2'b00, epc}, 32'h0000_0C03);
        chk("t4_exl", {31'd0, exl}, 32'd1);
        chk("t4_pc",  pc,           32'h0000_3040);
        fetch_now(32'hC000_0004);
        idle_inputs();
        intreq = 1'b1;
        npc    = 32'h0000_3044;
        #1;
        chk("t4_masked", {31'd0, int_ack}, 32'd0);
        cycle();
        chk("t4_epc_kept", {2'b00, epc}, 32'h0000_0C03);

        // 5: eret and intreq together
        fetch_now(32'hC000_0005);
        idle_inputs();
        intreq = 1'b1;
        eret   = 1'b1;
        npc    = 32'h0000_300C;
        #1;
        chk("t5_int_ack", {31'd0, int_ack}, 32'd0);
        cycle();
        chk("t5_exl", {31'd0, exl}, 32'd0);
        chk("t5_epc", {2'b00, epc}, 32'h0000_0C03);
        chk("t5_pc",  pc,           32'h0000_300C);

        // 6: misaligned npc
        fetch_now(32'hC000_0006);
        idle_inputs();
        npc = 32'h0000_3006;
`ifdef PC_ALIGN_CHECK_EN
        #1;
        chk("t6_addr_err", {31'd0, addr_err}, 32'd1);
        chk("t6_int_ack",  {31'd0, int_ack},  32'd1);
        cycle();
        chk("t6_pc", pc, 32'h0000_3040);
`else
        cycle();
        chk("t6_pc", pc, 32'h0000_3004);
`endif

        // pc_plus4 wraps at the top of the address space
        fetch_now(32'hC000_0007);
        advance_to(32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4, 32'h0000_0000);

        // reset mid-fetch; an ack arriving in idle is ignored
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_pc",  pc,                RST_PC);
        cycle();
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hEEEE_0000;
        cycle();
        chk("post_rst_addr",  imem_addr,            RST_PC);
        chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);

        // randomized traffic with a variable-latency memory
        mem_wait = 0;
        for (int n = 0; n < 600; n++) begin
            stall    = ($urandom % 3) == 0;
            flush    = ($urandom % 8) == 0;
            intreq   = ($urandom % 4) == 0;
            eret     = ($urandom % 6) == 0;
            npc      = (($urandom % 4) == 0) ? HND_PC : ($urandom & 32'hFFFF_FFFC);
            if (($urandom % 10) == 0) npc[1:0] = 2'($urandom);
            imem_ack = 1'b0;
            if (m_started && !m_have) begin
                if (mem_wait == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = $urandom;
                    mem_wait   = $urandom % 4;
                end else begin
                    mem_wait--;
                end
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
